// File: rtl/adder_with_feedback_pkg.sv
// Shared constants for the feedback-adder slice.
package adder_with_feedback_pkg;
  localparam int ACC_WIDTH = 16;
endpackage

// File: rtl/adder_with_feedback_adder_unit.sv
// Combinational unsigned adder; carry-out is dropped so the result wraps modulo 2^WIDTH.
module adder_unit
  import adder_with_feedback_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/adder_with_feedback.sv
// Running-sum accumulator: every rising clk edge adds `in` into acc; `out` is the register itself.
module adder_with_feedback
  import adder_with_feedback_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] sum;

  adder_unit #(.WIDTH(WIDTH)) u_add (
    .a   (acc_q),
    .b   (in),
    .sum (sum)
  );

  always_comb begin
    acc_d = sum;
  end

  // Async clear wins over an add on a coincident edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign out = acc_q;

endmodule

// File: tb/tb_adder_with_feedback.sv
// Randomized and directed check of the accumulator against a modulo-2^16 running-sum model.
`timescale 1ns/1ps
module tb_adder_with_feedback;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic [15:0] out;

  int total = 0;
  int bad   = 0;
  int model = 0;

  adder_with_feedback dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  always #25 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then advance the model past the rising edge.
  task automatic cyc(input logic r, input logic [15:0] v);
    @(negedge clk);
    reset = r;
    in    = v;
    @(posedge clk);
    #1;
    if (r) model = 0;
    else   model = (model + int'(v)) % 65536;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in    = 16'd5;

    // reset held across the first edge
    @(posedge clk); #1;
    chk("reset_edge", out, 16'd0);
    #9 reset = 1'b0;
    #5 chk("reset_release_midcycle", out, 16'd0);
    model = 0;

    // basic accumulate (in already 5 for the first edge)
    @(posedge clk); #1; model = 5;
    chk("acc_5", out, 16'(model));
    cyc(1'b0, 16'd5);   chk("acc_10", out, 16'(model));
    chk("acc_10_const", out, 16'd10);
    cyc(1'b0, 16'd200); chk("acc_210", out, 16'd210);

    // hold
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'd0);
      chk("hold_210", out, 16'd210);
    end

    // wrap-around
    cyc(1'b1, 16'd0);
    cyc(1'b0, 16'd65535); chk("to_ffff", out, 16'd65535);
    cyc(1'b0, 16'd1);     chk("wrap_0", out, 16'd0);
    cyc(1'b0, 16'd65000); chk("to_65000", out, 16'd65000);
    cyc(1'b0, 16'd1000);  chk("wrap_464", out, 16'd464);

    // async reset between edges
    cyc(1'b1, 16'd0);
    cyc(1'b0, 16'd210);   chk("pre_async", out, 16'd210);
    #19 reset = 1'b1;
    #1 chk("async_clear", out, 16'd0);
    model = 0;
    cyc(1'b1, 16'd7);     chk("reset_hold_1", out, 16'd0);
    cyc(1'b1, 16'd7);     chk("reset_hold_2", out, 16'd0);
    cyc(1'b0, 16'd7);     chk("post_release_7", out, 16'd7);

    // reset coincident with a rising edge beats the add
    @(negedge clk);
    reset = 1'b0;
    in    = 16'd9;
    @(posedge clk);
    reset = 1'b1;
    #1 chk("reset_priority", out, 16'd0);
    model = 0;
    cyc(1'b0, 16'd3);     chk("after_priority", out, 16'd3);

    // randomized run against the model
    for (int i = 0; i < 300; i++) begin
      logic        r;
      logic [15:0] v;
      r = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       v = 16'd0;
        1:       v = 16'($urandom_range(65000, 65535));
        default: v = 16'($urandom);
      endcase
      cyc(r, v);
      chk("random", out, 16'(model));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
